// File: rtl/mem_request_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_request_arbiter_if
//  Brief    : Datapath request lines and unified-RAM port bundled into one interface
//  Revision : 1.0
// ============================================================================
interface mem_request_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_timeout;

    // master: the arbiter itself; slave: the datapath plus RAM around it
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_timeout
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_request_arbiter
//  Brief    : Serializes instruction/data requests onto one RAM port, data first
//  Revision : 1.0
// ============================================================================
module mem_request_arbiter #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                   CLK,
    input  logic                   nRST,
    mem_request_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DSERVE = 3'd1,
        S_ISERVE = 3'd2,
        S_DRESP  = 3'd3,
        S_IRESP  = 3'd4
    } state_t;

    localparam logic [1:0]  c_ram_access = 2'd2;
    localparam logic [15:0] c_wait_limit = 16'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        timeout_q, timeout_d;
    logic        w_access;
    logic        w_serving;

    assign w_access = (bus.ramstate == c_ram_access);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            iload_q   <= '0;
            dload_q   <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        w_serving = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.dREN || bus.dWEN) begin
                    state_d = S_DSERVE;
                end else if (bus.iREN) begin
                    state_d = S_ISERVE;
                end
            end
            S_DSERVE: begin
                w_serving = 1'b1;
                if (!bus.dREN && !bus.dWEN) begin
                    state_d = S_IDLE;
                end else if (w_access) begin
                    state_d = S_DRESP;
                    // a simultaneous dREN/dWEN is a store, so it leaves dload alone
                    if (!bus.dWEN) begin
                        dload_d = bus.ramload;
                    end
                end
            end
            S_ISERVE: begin
                w_serving = 1'b1;
                if (!bus.iREN) begin
                    state_d = S_IDLE;
                end else if (w_access) begin
                    state_d = S_IRESP;
                    iload_d = bus.ramload;
                end
            end
            S_DRESP, S_IRESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_serving && !w_access) begin
            if (wcnt_q != c_wait_limit) begin
                wcnt_d = wcnt_q + 16'd1;
            end
            if (wcnt_d == c_wait_limit) begin
                timeout_d = 1'b1;
            end
        end
        if (state_d == S_IDLE) begin
            wcnt_d = '0;
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_q)
            S_DSERVE: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN && !bus.dWEN;
            end
            S_ISERVE: begin
                bus.ramaddr  = bus.iaddr;
                bus.ramREN   = 1'b1;
            end
            default: begin
                bus.ramREN   = 1'b0;
            end
        endcase
    end

    assign bus.ihit        = (state_q == S_IRESP);
    assign bus.dhit        = (state_q == S_DRESP);
    assign bus.iload       = iload_q;
    assign bus.dload       = dload_q;
    assign bus.mem_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_request_arbiter
//  Brief    : Vector table, directed corner sequences and randomized model check
//  Revision : 1.0
// ============================================================================
module tb_mem_request_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERR = 2'd3;

    logic CLK;
    logic nRST;
    int   n_chk;
    int   n_err;

    mem_request_arbiter_if bus ();

    mem_request_arbiter #(.WAIT_LIMIT(LIMIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren, dren, dwen;
        logic [1:0]  rs;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic        e_ihit, e_dhit, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iren, input logic dren, input logic dwen, input logic [1:0] rs,
                          input logic [31:0] iaddr, input logic [31:0] daddr,
                          input logic [31:0] dstore, input logic [31:0] rload);
        bus.iREN     = iren;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.ramstate = rs;
        bus.iaddr    = iaddr;
        bus.daddr    = daddr;
        bus.dstore   = dstore;
        bus.ramload  = rload;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        set_in(0, 0, 0, FREE, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic add(input logic iren, input logic dren, input logic dwen, input logic [1:0] rs,
                       input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] dstore,
                       input logic [31:0] rload, input logic e_ihit, input logic e_dhit,
                       input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                       input logic [31:0] e_store, input logic [31:0] e_iload, input logic [31:0] e_dload);
        vec_t v;
        v = '{iren, dren, dwen, rs, iaddr, daddr, dstore, rload,
              e_ihit, e_dhit, e_ren, e_wen, e_addr, e_store, e_iload, e_dload};
        tbl.push_back(v);
    endtask

    // reference model state: what the controller is busy with, as a phase number
    int          m_ph;     // 0 idle, 1 serving data, 2 serving fetch, 3 data reply, 4 fetch reply
    int          m_wait;
    bit          m_to;
    logic [31:0] m_il, m_dl;

    initial begin
        bit          dpend, dwr, ipend;
        logic [31:0] da, ds, ia;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_ren, e_wen, e_ih, e_dh;
        logic [31:0] e_addr, e_store;
        int          nxt;
        bit          acc;

        n_chk = 0;
        n_err = 0;
        do_reset();

        // ---------------- table-driven vectors ----------------
        add(1,0,0,ACCESS,32'h40,0,0,32'h8C220004, 0,0,0,0,0,0,0,0);
        add(1,0,0,ACCESS,32'h40,0,0,32'h8C220004, 0,0,1,0,32'h40,0,0,0);
        add(1,0,0,ACCESS,32'h40,0,0,32'h8C220004, 1,0,0,0,0,0,32'h8C220004,0);
        add(0,0,0,FREE,0,0,0,0,                   0,0,0,0,0,0,32'h8C220004,0);
        add(1,1,0,BUSY,32'h44,32'h100,0,0,        0,0,0,0,0,0,32'h8C220004,0);
        add(1,1,0,BUSY,32'h44,32'h100,0,0,        0,0,1,0,32'h100,0,32'h8C220004,0);
        add(1,1,0,BUSY,32'h44,32'h100,0,0,        0,0,1,0,32'h100,0,32'h8C220004,0);
        add(1,1,0,ACCESS,32'h44,32'h100,0,32'h11112222, 0,0,1,0,32'h100,0,32'h8C220004,0);
        add(1,1,0,FREE,32'h44,32'h100,0,0,        0,1,0,0,0,0,32'h8C220004,32'h11112222);
        add(1,0,0,ACCESS,32'h44,0,0,32'h33334444, 0,0,0,0,0,0,32'h8C220004,32'h11112222);
        add(1,0,0,ACCESS,32'h44,0,0,32'h33334444, 0,0,1,0,32'h44,0,32'h8C220004,32'h11112222);
        add(1,0,0,FREE,32'h44,0,0,0,              1,0,0,0,0,0,32'h33334444,32'h11112222);
        add(0,0,0,FREE,0,0,0,0,                   0,0,0,0,0,0,32'h33334444,32'h11112222);
        add(0,1,1,FREE,0,32'h300,32'hA5A5A5A5,0,  0,0,0,0,0,0,32'h33334444,32'h11112222);
        add(0,1,1,ACCESS,0,32'h300,32'hA5A5A5A5,32'hFFFF0000, 0,0,0,1,32'h300,32'hA5A5A5A5,32'h33334444,32'h11112222);
        add(0,1,1,FREE,0,32'h300,32'hA5A5A5A5,0,  0,1,0,0,0,0,32'h33334444,32'h11112222);
        add(0,0,0,FREE,0,0,0,0,                   0,0,0,0,0,0,32'h33334444,32'h11112222);

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].rs,
                   tbl[i].iaddr, tbl[i].daddr, tbl[i].dstore, tbl[i].rload);
            chk($sformatf("vec%0d ihit", i),     32'(bus.ihit),   32'(tbl[i].e_ihit));
            chk($sformatf("vec%0d dhit", i),     32'(bus.dhit),   32'(tbl[i].e_dhit));
            chk($sformatf("vec%0d ramREN", i),   32'(bus.ramREN), 32'(tbl[i].e_ren));
            chk($sformatf("vec%0d ramWEN", i),   32'(bus.ramWEN), 32'(tbl[i].e_wen));
            chk($sformatf("vec%0d ramaddr", i),  bus.ramaddr,     tbl[i].e_addr);
            chk($sformatf("vec%0d ramstore", i), bus.ramstore,    tbl[i].e_store);
            chk($sformatf("vec%0d iload", i),    bus.iload,       tbl[i].e_iload);
            chk($sformatf("vec%0d dload", i),    bus.dload,       tbl[i].e_dload);
            chk($sformatf("vec%0d timeout", i),  32'(bus.mem_timeout), 32'd0);
            tick();
        end

        // ---------------- store held through 3 BUSY cycles ----------------
        set_in(0,0,1,BUSY,0,32'h200,32'hDEADBEEF,0);
        chk("st idle ramWEN", 32'(bus.ramWEN), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(0,0,1,(k == 3) ? ACCESS : BUSY,0,32'h200,32'hDEADBEEF,32'h12345678);
            chk($sformatf("st%0d ramWEN", k),   32'(bus.ramWEN), 32'd1);
            chk($sformatf("st%0d ramREN", k),   32'(bus.ramREN), 32'd0);
            chk($sformatf("st%0d ramstore", k), bus.ramstore,    32'hDEADBEEF);
            chk($sformatf("st%0d ramaddr", k),  bus.ramaddr,     32'h200);
            chk($sformatf("st%0d dhit", k),     32'(bus.dhit),   32'd0);
            tick();
        end
        set_in(0,0,1,FREE,0,32'h200,32'hDEADBEEF,0);
        chk("st dhit", 32'(bus.dhit), 32'd1);
        chk("st dload kept", bus.dload, 32'h11112222);
        chk("st ramWEN resp", 32'(bus.ramWEN), 32'd0);
        chk("st timeout", 32'(bus.mem_timeout), 32'd0);
        tick();
        set_in(0,0,0,FREE,0,0,0,0);
        chk("st dhit gone", 32'(bus.dhit), 32'd0);

        // ---------------- fetch withdrawn while waiting ----------------
        set_in(1,0,0,BUSY,32'h80,0,0,0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1,0,0,BUSY,32'h80,0,0,0);
            chk($sformatf("wd%0d ramREN", k),  32'(bus.ramREN), 32'd1);
            chk($sformatf("wd%0d ramaddr", k), bus.ramaddr,     32'h80);
            tick();
        end
        set_in(0,0,0,BUSY,32'h80,0,0,0);
        chk("wd drop ihit", 32'(bus.ihit), 32'd0);
        tick();
        chk("wd idle ramREN", 32'(bus.ramREN), 32'd0);
        chk("wd idle ihit", 32'(bus.ihit), 32'd0);
        tick();
        chk("wd later ihit", 32'(bus.ihit), 32'd0);

        // ---------------- watchdog with RAM stuck BUSY ----------------
        set_in(0,1,0,BUSY,0,32'h400,0,0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(0,1,0,BUSY,0,32'h400,0,0);
            chk($sformatf("wdog before wait%0d", k + 1), 32'(bus.mem_timeout), 32'd0);
            tick();
        end
        chk("wdog set", 32'(bus.mem_timeout), 32'd1);
        tick();
        set_in(0,1,0,ACCESS,0,32'h400,0,32'h55AA55AA);
        chk("wdog sat", 32'(bus.mem_timeout), 32'd1);
        tick();
        set_in(0,1,0,FREE,0,32'h400,0,0);
        chk("wdog dhit", 32'(bus.dhit), 32'd1);
        chk("wdog dload", bus.dload, 32'h55AA55AA);
        tick();
        set_in(0,0,0,FREE,0,0,0,0);
        chk("wdog sticky", 32'(bus.mem_timeout), 32'd1);
        tick();
        chk("wdog sticky idle", 32'(bus.mem_timeout), 32'd1);
        nRST = 1'b0;
        #1;
        chk("wdog reset", 32'(bus.mem_timeout), 32'd0);
        nRST = 1'b1;
        tick();

        // ---------------- reset mid-DSERVE ----------------
        set_in(0,1,0,BUSY,0,32'h500,0,0);
        tick();
        chk("rst serve ramREN", 32'(bus.ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst ramREN",  32'(bus.ramREN),  32'd0);
        chk("rst ramaddr", bus.ramaddr,      32'd0);
        chk("rst dhit",    32'(bus.dhit),    32'd0);
        chk("rst dload",   bus.dload,        32'd0);
        chk("rst iload",   bus.iload,        32'd0);
        nRST = 1'b1;
        set_in(0,0,0,FREE,0,0,0,0);
        tick();
        chk("rst no dhit", 32'(bus.dhit), 32'd0);
        set_in(0,1,0,ACCESS,0,32'h600,0,32'hCAFEF00D);
        chk("rst idle ramREN", 32'(bus.ramREN), 32'd0);
        tick();
        chk("rst new ramREN",  32'(bus.ramREN), 32'd1);
        chk("rst new ramaddr", bus.ramaddr,     32'h600);
        tick();
        set_in(0,1,0,FREE,0,32'h600,0,0);
        chk("rst new dhit",  32'(bus.dhit), 32'd1);
        chk("rst new dload", bus.dload,     32'hCAFEF00D);
        tick();
        set_in(0,0,0,FREE,0,0,0,0);
        chk("rst new dhit gone", 32'(bus.dhit), 32'd0);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_ph = 0; m_wait = 0; m_to = 0; m_il = '0; m_dl = '0;
        dpend = 0; dwr = 0; ipend = 0; da = '0; ds = '0; ia = '0;
        for (int c = 0; c < 600; c++) begin
            if (!dpend && ($urandom_range(0, 3) == 0)) begin
                dpend = 1; dwr = $urandom_range(0, 1) == 1; da = $urandom; ds = $urandom;
            end
            if (!ipend && ($urandom_range(0, 2) == 0)) begin
                ipend = 1; ia = $urandom;
            end
            rs = 2'($urandom_range(0, 3));
            rl = $urandom;
            set_in(ipend, dpend && !dwr, dpend && dwr, rs, ia, da, ds, rl);

            e_ren   = (m_ph == 1) ? (bus.dREN && !bus.dWEN) : (m_ph == 2);
            e_wen   = (m_ph == 1) && bus.dWEN;
            e_addr  = (m_ph == 1) ? da : ((m_ph == 2) ? ia : 32'd0);
            e_store = (m_ph == 1) ? ds : 32'd0;
            e_ih    = (m_ph == 4);
            e_dh    = (m_ph == 3);
            chk("rnd ihit",     32'(bus.ihit),   32'(e_ih));
            chk("rnd dhit",     32'(bus.dhit),   32'(e_dh));
            chk("rnd ramREN",   32'(bus.ramREN), 32'(e_ren));
            chk("rnd ramWEN",   32'(bus.ramWEN), 32'(e_wen));
            chk("rnd ramaddr",  bus.ramaddr,     e_addr);
            chk("rnd ramstore", bus.ramstore,    e_store);
            chk("rnd iload",    bus.iload,       m_il);
            chk("rnd dload",    bus.dload,       m_dl);
            chk("rnd timeout",  32'(bus.mem_timeout), 32'(m_to));
            chk("rnd hit overlap", 32'(bus.ihit && bus.dhit), 32'd0);

            acc = (rs == ACCESS);
            nxt = m_ph;
            case (m_ph)
                0: nxt = dpend ? 1 : (ipend ? 2 : 0);
                1: if (acc) begin nxt = 3; if (!dwr) m_dl = rl; end
                2: if (acc) begin nxt = 4; m_il = rl; end
                default: nxt = 0;
            endcase
            if ((m_ph == 1 || m_ph == 2) && !acc) begin
                if (m_wait < LIMIT) m_wait++;
                if (m_wait == LIMIT) m_to = 1;
            end
            if (nxt == 0) m_wait = 0;
            m_ph = nxt;

            if (e_dh) dpend = 0;
            if (e_ih) ipend = 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Single-port memory controller that sits between the pipelined datapath's instruction/data request lines and the unified RAM.
- Serializes iREN, dREN and dWEN onto one RAM port and produces the ihit/dhit pulses that drive the pipeline enable/flush logic, plus the returned load words.
- Data requests take priority over instruction fetches.
- Responses are registered: each hit is a clean one-cycle pulse, and ihit and dhit are never high in the same cycle.

Parameters:
- WAIT_LIMIT, 255, number of consecutive non-ACCESS cycles in a serve state before mem_timeout sets (valid range 1..65535).

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction fetch request, held until ihit
- iaddr  input  32  instruction word address
- dREN  input  1  data load request, held until dhit
- dWEN  input  1  data store request, held until dhit; dREN and dWEN are mutually exclusive
- daddr  input  32  data address
- dstore  input  32  store data
- ihit  output  1  one-cycle pulse: iload valid
- iload  output  32  fetched instruction
- dhit  output  1  one-cycle pulse: load/store complete, dload valid for loads
- dload  output  32  loaded data
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ramstate==ACCESS
- ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset values (async on nRST low): state=IDLE, ihit=dhit=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, wait counter=0, mem_timeout=0. Reset mid-transaction abandons it; no hit is issued.
- States: IDLE, DSERVE, ISERVE, DRESP, IRESP.
- IDLE:
  - (dREN|dWEN) -> DSERVE.
  - else iREN -> ISERVE.
  - else stay.
  - Priority is data over instruction, so a load stalled behind a fetch completes before the next fetch.
- DSERVE:
  - Drives ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore.
  - ramstate==ACCESS: latch dload<=ramload (loads only; dload holds its value on stores) -> DRESP.
  - dREN and dWEN both low (request withdrawn): -> IDLE, no hit, RAM strobes drop.
  - BUSY, FREE or ERROR: stay and retry. ERROR is treated as not-ready.
- ISERVE:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ACCESS: iload<=ramload -> IRESP.
  - iREN low: -> IDLE.
  - Otherwise stay.
  - A data request arriving mid-ISERVE does not preempt; it waits.
- DRESP / IRESP:
  - RAM strobes low; ramaddr=0.
  - dhit (resp. ihit)=1 for exactly this cycle -> IDLE unconditionally.
  - The requester drops or changes its request on the following edge.
- Outputs: ihit/dhit are decoded from the registered state only. All RAM outputs are 0 in IDLE and RESP.
- Latency: request visible in cycle N -> serve in N+1. If ACCESS arrives in N+1, hit pulses in N+2. Minimum 2 cycles; the RESP/IDLE turnaround adds one more cycle between back-to-back transactions (3-cycle initiation interval).
- Watchdog:
  - 16-bit counter increments each serve-state cycle whose ramstate!=ACCESS.
  - Clears on entry to IDLE.
  - When it equals WAIT_LIMIT, mem_timeout<=1 and the counter saturates.
  - mem_timeout is sticky until reset and has no effect on the FSM.
- Illegal dREN&dWEN in the same cycle: treated as write (ramWEN=1, ramREN=0).

Test Plan:
- Reset with iREN=1, iaddr=0x40, RAM returning ACCESS/0x8C220004 immediately -> ramREN high in cycle 1 with ramaddr=0x40; ihit=1 with iload=0x8C220004 in cycle 2 only; ihit=0 in cycle 3.
- iREN=1 and dREN=1 asserted together, daddr=0x100, RAM latency 2 BUSY cycles -> dhit first with dload=ramload; ihit no earlier than 3 cycles after dhit; never both high in one cycle.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF, RAM ACCESS after 3 BUSY -> ramWEN=1, ramstore=0xDEADBEEF held for 4 cycles; dhit one cycle later; dload unchanged.
- iREN dropped after 2 BUSY cycles in ISERVE -> return to IDLE, no ihit, ramREN=0 next cycle.
- WAIT_LIMIT=4, ramstate stuck BUSY -> mem_timeout=1 after the 4th wait cycle, stays 1 after ACCESS and completion, clears only on nRST.
- nRST pulsed low mid-DSERVE -> all outputs 0 immediately; no dhit; the next transaction starts from IDLE.
